// File: rtl/usr_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : usr_deserializer
// Purpose  : Serial-to-parallel word assembler with selectable bit order,
//            a single-word output holding register, and a sticky overrun flag.
// Revision : 1.0 - initial release
// ============================================================================
module usr_deserializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             dir,
  input  logic             flush,
  output logic [WIDTH-1:0] po,
  output logic             po_valid,
  input  logic             po_ready,
  output logic             busy,
  output logic             overrun
);

  localparam int                 c_CNT_W    = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(WIDTH - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_sreg;
  logic [c_CNT_W-1:0] r_cnt;
  logic [c_CNT_W-1:0] w_cnt_nxt;
  logic               r_dir_q;
  logic [WIDTH-1:0]   r_po;
  logic               r_po_valid;
  logic               r_overrun;

  logic               w_accept;
  logic               w_complete;
  logic               w_dir_eff;
  logic [WIDTH-1:0]   w_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // The first bit of a word uses the live dir; later bits use the latched copy.
  always_comb begin
    w_accept    = sin_valid && !flush;
    w_dir_eff   = (r_state == IDLE) ? dir : r_dir_q;
    w_shifted   = w_dir_eff ? {r_sreg[WIDTH-2:0], sin} : {sin, r_sreg[WIDTH-1:1]};
    w_complete  = w_accept && (r_cnt == c_CNT_LAST);
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (flush) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_complete) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (w_accept) begin
      w_state_nxt = SHIFT;
      w_cnt_nxt   = r_cnt + c_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sreg  <= '0;
      r_dir_q <= 1'b0;
    end else if (w_accept) begin
      r_sreg <= w_shifted;
      if (r_state == IDLE) begin
        r_dir_q <= dir;
      end
    end
  end

  // Output register: a completing word is dropped only if the held word stays unconsumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_po       <= '0;
      r_po_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_complete && (!r_po_valid || po_ready)) begin
        r_po       <= w_shifted;
        r_po_valid <= 1'b1;
      end else if (r_po_valid && po_ready) begin
        r_po_valid <= 1'b0;
      end
      if (flush) begin
        r_overrun <= 1'b0;
      end else if (w_complete && r_po_valid && !po_ready) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign po       = r_po;
  assign po_valid = r_po_valid;
  assign busy     = (r_state == SHIFT);
  assign overrun  = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_usr_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usr_deserializer
// Purpose  : Scoreboard bench for usr_deserializer (WIDTH=4), directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usr_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin;
  logic       sin_valid;
  logic       dir;
  logic       flush;
  logic [3:0] po;
  logic       po_valid;
  logic       po_ready;
  logic       busy;
  logic       overrun;

  int         total = 0;
  int         bad   = 0;
  logic [3:0] exp_q[$];

  usr_deserializer #(.WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .sin       (sin),
    .sin_valid (sin_valid),
    .dir       (dir),
    .flush     (flush),
    .po        (po),
    .po_valid  (po_valid),
    .po_ready  (po_ready),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send_bit(input logic b, input logic d);
    sin       = b;
    dir       = d;
    sin_valid = 1'b1;
    tick();
    sin_valid = 1'b0;
  endtask

  // Monitor: every handshake consumes the oldest expected word.
  always @(negedge clk) begin
    if (!rst && po_valid && po_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL scoreboard: unexpected word %0h", po);
      end else begin
        chk("sb_word", 32'(po), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; sin = 1'b0; sin_valid = 1'b0; dir = 1'b0; flush = 1'b0; po_ready = 1'b0;
    idle(2);
    rst = 1'b0;
    chk("rst_po", 32'(po), 32'h0);
    chk("rst_po_valid", 32'(po_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_overrun", 32'(overrun), 32'h0);

    // MSB-first 1010, consumer ready
    po_ready = 1'b1;
    send_bit(1'b1, 1'b1);
    chk("msb_busy1", 32'(busy), 32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    chk("msb_novalid3", 32'(po_valid), 32'h0);
    exp_q.push_back(4'b1010);
    send_bit(1'b0, 1'b1);
    chk("msb_po", 32'(po), 32'hA);
    chk("msb_valid", 32'(po_valid), 32'h1);
    chk("msb_busy_done", 32'(busy), 32'h0);
    tick();
    chk("msb_cleared", 32'(po_valid), 32'h0);
    chk("msb_po_kept", 32'(po), 32'hA);

    // LSB-first 1,0,1,0 with gaps and a dir toggle mid-word -> 0101
    send_bit(1'b1, 1'b0);
    chk("lsb_busy1", 32'(busy), 32'h1);
    idle(1);
    send_bit(1'b0, 1'b0);
    idle(2);
    send_bit(1'b1, 1'b1);
    chk("lsb_busy3", 32'(busy), 32'h1);
    idle(3);
    exp_q.push_back(4'b0101);
    send_bit(1'b0, 1'b1);
    chk("lsb_po", 32'(po), 32'h5);
    chk("lsb_valid", 32'(po_valid), 32'h1);
    chk("lsb_busy_done", 32'(busy), 32'h0);
    tick();
    chk("lsb_cleared", 32'(po_valid), 32'h0);

    // Overrun: 1100 held, 0011 dropped
    po_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    exp_q.push_back(4'b1100);
    send_bit(1'b0, 1'b1);
    chk("ovr_first_overrun", 32'(overrun), 32'h0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    chk("ovr_overrun", 32'(overrun), 32'h1);
    chk("ovr_po_kept", 32'(po), 32'hC);
    chk("ovr_valid_kept", 32'(po_valid), 32'h1);
    idle(2);
    chk("ovr_sticky", 32'(overrun), 32'h1);
    po_ready = 1'b1;
    tick();
    chk("ovr_consumed", 32'(po_valid), 32'h0);
    chk("ovr_still_set", 32'(overrun), 32'h1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("ovr_flush_clear", 32'(overrun), 32'h0);

    // Flush discards a partial word; flush beats sin_valid
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    chk("fl_busy", 32'(busy), 32'h1);
    flush = 1'b1;
    send_bit(1'b1, 1'b1);
    flush = 1'b0;
    chk("fl_busy_clear", 32'(busy), 32'h0);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    exp_q.push_back(4'b0110);
    send_bit(1'b0, 1'b1);
    chk("fl_po", 32'(po), 32'h6);
    chk("fl_valid", 32'(po_valid), 32'h1);
    chk("fl_no_overrun", 32'(overrun), 32'h0);
    tick();
    chk("fl_cleared", 32'(po_valid), 32'h0);

    // Same-cycle consume and completion keeps po_valid high
    po_ready = 1'b0;
    exp_q.push_back(4'b0110);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b1, 1'b1);
    chk("bb_valid1", 32'(po_valid), 32'h1);
    send_bit(1'b0, 1'b1);
    send_bit(1'b0, 1'b1);
    chk("bb_valid3", 32'(po_valid), 32'h1);
    po_ready = 1'b1;
    exp_q.push_back(4'b1001);
    send_bit(1'b1, 1'b1);
    chk("bb_po", 32'(po), 32'h9);
    chk("bb_valid", 32'(po_valid), 32'h1);
    chk("bb_no_overrun", 32'(overrun), 32'h0);
    tick();
    chk("bb_cleared", 32'(po_valid), 32'h0);

    // Reset mid-word with a held word
    po_ready = 1'b0;
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("mr_pre_valid", 32'(po_valid), 32'h1);
    chk("mr_pre_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    chk("mr_po", 32'(po), 32'h0);
    chk("mr_valid", 32'(po_valid), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    chk("mr_overrun", 32'(overrun), 32'h0);
    po_ready = 1'b1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    exp_q.push_back(4'b1011);
    send_bit(1'b1, 1'b0);
    chk("mr_fresh_po", 32'(po), 32'hB);
    chk("mr_fresh_valid", 32'(po_valid), 32'h1);
    idle(2);
    chk("sb_drained", 32'(exp_q.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
